// File: rtl/adder_share_ctrl_pkg.sv
// nrisc_pkg: shared FSM encoding, default datapath width and requester IDs for the nRisc core.
package nrisc_pkg;
  localparam int WIDTH = 8;
  localparam int ID_PC = 0;
  localparam int ID_BR = 1;
  localparam int ID_ALU = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/adder_share_ctrl_if.sv
// adder_share_ctrl_if: requester operand handshake and result response bundle for the shared adder.
interface adder_share_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NREQ = 3,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_sub;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic resp_valid;
  logic resp_ready;
  logic [IDW-1:0] resp_id;
  logic [WIDTH-1:0] resp_sum;
  logic resp_carry;
  logic resp_ovf;
  modport master (
    output req_valid, req_sub, req_a, req_b, resp_ready,
    input req_ready, resp_valid, resp_id, resp_sum, resp_carry, resp_ovf
  );
  modport slave (
    input req_valid, req_sub, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_carry, resp_ovf
  );
endinterface

// File: rtl/adder_share_ctrl_rr_picker.sv
// rr_picker: combinational round-robin pick, searching upward from ptr and wrapping at NREQ.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int IDW = 2
) (
  input logic [NREQ-1:0] valid,
  input logic [IDW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0] grant_id
);
  logic [IDW-1:0] idx [NREQ];
  logic found;
  for (genvar k = 0; k < NREQ; k++) begin : g_idx
    assign idx[k] = IDW'((int'(ptr) + k) % NREQ);
  end
  always_comb begin
    grant = '0;
    grant_id = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[idx[k]]) begin
        found = 1'b1;
        grant_id = idx[k];
        grant[idx[k]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: time-shares one registered adder among NREQ requesters via an IDLE/EXEC/RESP cycle.
module adder_share_ctrl #(
  parameter int WIDTH = nrisc_pkg::WIDTH,
  parameter int NREQ = 3,
  parameter int IDW = 2
) (
  input logic clock,
  input logic reset_n,
  adder_share_ctrl_if.slave bus
);
  import nrisc_pkg::*;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, gid, op_id, res_id;
  logic [NREQ-1:0] grant;
  logic [WIDTH-1:0] op_a, op_b, eff_b, res_sum;
  logic [WIDTH:0] sum;
  logic op_sub, res_carry, res_ovf, hs, acc;
  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid(bus.req_valid),
    .ptr(ptr),
    .grant(grant),
    .grant_id(gid)
  );
  assign hs = state == IDLE && |bus.req_valid;
  assign acc = state == RESP && bus.resp_ready;
  // subtract is A + ~B + 1; carry-out of 1 then means no borrow
  assign eff_b = op_sub ? ~op_b : op_b;
  assign sum = {1'b0, op_a} + {1'b0, eff_b} + {{WIDTH{1'b0}}, op_sub};
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (hs ? EXEC : IDLE) : state == EXEC ? RESP : (acc ? IDLE : RESP);
    bus.req_ready = state == IDLE ? grant : '0;
    bus.resp_valid = state == RESP;
  end
  assign bus.resp_id = res_id;
  assign bus.resp_sum = res_sum;
  assign bus.resp_carry = res_carry;
  assign bus.resp_ovf = res_ovf;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      op_sub <= 1'b0;
      op_id <= '0;
      res_sum <= '0;
      res_carry <= 1'b0;
      res_ovf <= 1'b0;
      res_id <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        op_a <= bus.req_a[int'(gid)*WIDTH +: WIDTH];
        op_b <= bus.req_b[int'(gid)*WIDTH +: WIDTH];
        op_sub <= bus.req_sub[gid];
        op_id <= gid;
      end
      if (state == EXEC) begin
        res_sum <= sum[WIDTH-1:0];
        res_carry <= sum[WIDTH];
        res_ovf <= (op_a[WIDTH-1] == eff_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        res_id <= op_id;
      end
      // the requester just served drops to lowest priority
      if (acc) ptr <= IDW'((int'(res_id) + 1) % NREQ);
    end
  end
endmodule
